// File: rtl/io_arb_pkg.sv
// ============================================================================
// io_arb_pkg : shared FSM encoding, master indices and default timing
// Revision   : 1.0
// ============================================================================
`default_nettype none

package io_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int unsigned DEFAULT_ACCESS_CYCLES = 2;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
// rr_pick2 : two-way round-robin winner select with sticky lock override
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,        // index of the master granted most recently
  input  logic lock_i,
  input  logic lock_owner_i,
  output logic valid_o,
  output logic winner_o
);
  import io_arb_pkg::*;

  logic w_owner_req;

  assign w_owner_req = (lock_owner_i == M1) ? req1_i : req0_i;

  always_comb begin
    valid_o  = req0_i | req1_i;
    winner_o = M0;
    if (lock_i && w_owner_req) begin
      winner_o = lock_owner_i;
    end else if (req0_i && req1_i) begin
      winner_o = ~last_i;
    end else if (req1_i) begin
      winner_o = M1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/io_bus_arbiter.sv
// ============================================================================
// io_bus_arbiter : two-master arbiter driving a strobed peripheral IO bus
// Revision       : 1.0
// ============================================================================
`default_nettype none

module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              m0_req,
  input  logic              m0_rd,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_rd,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              io_rd,
  output logic              io_wr,
  output logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_dout,
  input  logic [DATA_W-1:0] io_din,
  output logic              busy,
  output logic              owner
);

  localparam logic [3:0] c_hold_last = 4'(ACCESS_CYCLES - 1);

  arb_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ptr_q, ptr_d;
  logic              lock_q, lock_d;
  logic              owner_q, owner_d;
  logic              rd_q, wr_q;
  logic [ADDR_W-1:0] io_addr_q;
  logic [DATA_W-1:0] io_dout_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic              w_valid, w_win, w_grant, w_capture;
  logic              w_rd, w_wr, w_lock;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  rr_pick2 u_pick (
    .req0_i       (m0_req),
    .req1_i       (m1_req),
    .last_i       (ptr_q),
    .lock_i       (lock_q),
    .lock_owner_i (owner_q),
    .valid_o      (w_valid),
    .winner_o     (w_win)
  );

  assign w_rd    = (w_win == M1) ? m1_rd    : m0_rd;
  assign w_wr    = (w_win == M1) ? m1_wr    : m0_wr;
  assign w_lock  = (w_win == M1) ? m1_lock  : m0_lock;
  assign w_addr  = (w_win == M1) ? m1_addr  : m0_addr;
  assign w_wdata = (w_win == M1) ? m1_wdata : m0_wdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    owner_d   = owner_q;
    w_grant   = 1'b0;
    w_capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_valid) begin
          w_grant = 1'b1;
          owner_d = w_win;
          lock_d  = w_lock;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        cnt_d   = 4'd0;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_q == c_hold_last) begin
          // Write wins over read when both flags are set, so only pure reads capture.
          w_capture = rd_q & ~wr_q;
          cnt_d     = 4'd0;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        ptr_d   = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pointer resets to M1 so that m0 wins the first contended grant.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      ptr_q     <= M1;
      lock_q    <= 1'b0;
      owner_q   <= M0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      io_addr_q <= '0;
      io_dout_q <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      owner_q <= owner_d;
      if (w_grant) begin
        rd_q      <= w_rd;
        wr_q      <= w_wr;
        io_addr_q <= w_addr;
        io_dout_q <= w_wdata;
      end
      if (w_capture) begin
        if (owner_q == M1) rdata1_q <= io_din;
        else               rdata0_q <= io_din;
      end
    end
  end

  assign io_wr    = (state_q == ST_STROBE) & wr_q;
  assign io_rd    = (state_q == ST_STROBE) & rd_q & ~wr_q;
  assign m0_ack   = (state_q == ST_DONE) & (owner_q == M0);
  assign m1_ack   = (state_q == ST_DONE) & (owner_q == M1);
  assign busy     = (state_q != ST_IDLE);
  assign owner    = owner_q;
  assign io_addr  = io_addr_q;
  assign io_dout  = io_dout_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

endmodule

`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
// ============================================================================
// tb_io_bus_arbiter : directed stimulus with queued expectations and a monitor
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_io_bus_arbiter;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] dout;
    logic        mst;
  } strobe_t;

  typedef struct {
    int          cyc;
    logic        mst;
    logic [15:0] r0;
    logic [15:0] r1;
  } ack_t;

  logic        sys_clk_i = 1'b0;
  logic        sys_rst_i;
  logic        m0_req, m0_rd, m0_wr, m0_lock;
  logic        m1_req, m1_rd, m1_wr, m1_lock;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [15:0] m0_rdata, m1_rdata;
  logic        io_rd, io_wr;
  logic [15:0] io_addr, io_dout, io_din;
  logic        busy, owner;

  int      cyc   = 0;
  int      tests = 0;
  int      fails = 0;
  strobe_t sq[$];
  ack_t    aq[$];
  strobe_t ms;
  ack_t    ma;
  int      c;

  io_bus_arbiter dut (
    .sys_clk_i (sys_clk_i), .sys_rst_i (sys_rst_i),
    .m0_req (m0_req), .m0_rd (m0_rd), .m0_wr (m0_wr), .m0_addr (m0_addr),
    .m0_wdata (m0_wdata), .m0_lock (m0_lock), .m0_ack (m0_ack), .m0_rdata (m0_rdata),
    .m1_req (m1_req), .m1_rd (m1_rd), .m1_wr (m1_wr), .m1_addr (m1_addr),
    .m1_wdata (m1_wdata), .m1_lock (m1_lock), .m1_ack (m1_ack), .m1_rdata (m1_rdata),
    .io_rd (io_rd), .io_wr (io_wr), .io_addr (io_addr), .io_dout (io_dout),
    .io_din (io_din), .busy (busy), .owner (owner)
  );

  always #5 sys_clk_i = ~sys_clk_i;
  always @(posedge sys_clk_i) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_s(input int cy, input logic wr, input logic [15:0] a,
                                 input logic [15:0] d, input logic m);
    strobe_t s;
    s.cyc = cy; s.wr = wr; s.addr = a; s.dout = d; s.mst = m;
    sq.push_back(s);
  endfunction

  function automatic void push_a(input int cy, input logic m, input logic [15:0] r0,
                                 input logic [15:0] r1);
    ack_t a;
    a.cyc = cy; a.mst = m; a.r0 = r0; a.r1 = r1;
    aq.push_back(a);
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_io_rd"}, io_rd, 0);
    chk({tag, "_io_wr"}, io_wr, 0);
    chk({tag, "_m0_ack"}, m0_ack, 0);
    chk({tag, "_m1_ack"}, m1_ack, 0);
    chk({tag, "_owner"}, owner, 0);
    chk({tag, "_io_addr"}, io_addr, 0);
    chk({tag, "_io_dout"}, io_dout, 0);
    chk({tag, "_m0_rdata"}, m0_rdata, 0);
    chk({tag, "_m1_rdata"}, m1_rdata, 0);
  endtask

  // Waits for n acks of any master, optionally dropping m0_lock after the second.
  task automatic wait_acks(input int n, input string tag, input bit unlock_at2);
    int got = 0;
    for (int i = 0; i < 120 && got < n; i++) begin
      @(negedge sys_clk_i);
      if (m0_ack || m1_ack) begin
        got++;
        if (unlock_at2 && got == 2) m0_lock = 1'b0;
      end
    end
    if (got < n) begin
      tests++;
      fails++;
      $display("FAIL %s_ack_timeout: got %0d acks expected %0d", tag, got, n);
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  task automatic set_m0(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input logic lk);
    m0_req = 1'b1; m0_rd = rd; m0_wr = wr; m0_addr = a; m0_wdata = d; m0_lock = lk;
  endtask

  task automatic set_m1(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input logic lk);
    m1_req = 1'b1; m1_rd = rd; m1_wr = wr; m1_addr = a; m1_wdata = d; m1_lock = lk;
  endtask

  always @(negedge sys_clk_i) begin
    if (sys_rst_i) begin
      if (io_rd && io_wr) begin
        tests++; fails++;
        $display("FAIL both_strobes: io_rd=1 io_wr=1 required at most one (cycle %0d)", cyc);
      end
      if (m0_ack && m1_ack) begin
        tests++; fails++;
        $display("FAIL both_acks: m0_ack=1 m1_ack=1 required at most one (cycle %0d)", cyc);
      end
      if (io_rd || io_wr) begin
        if (sq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_strobe: rd=%0b wr=%0b addr=0x%0h required none (cycle %0d)",
                   io_rd, io_wr, io_addr, cyc);
        end else begin
          ms = sq.pop_front();
          chk("strobe_cycle", cyc, ms.cyc);
          chk("strobe_is_wr", io_wr, ms.wr);
          chk("strobe_addr", io_addr, ms.addr);
          chk("strobe_dout", io_dout, ms.dout);
          chk("strobe_owner", owner, ms.mst);
          chk("strobe_busy", busy, 1);
        end
      end
      if (m0_ack || m1_ack) begin
        if (aq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_ack: m0_ack=%0b m1_ack=%0b required none (cycle %0d)",
                   m0_ack, m1_ack, cyc);
        end else begin
          ma = aq.pop_front();
          chk("ack_cycle", cyc, ma.cyc);
          chk("ack_master", m1_ack, ma.mst);
          chk("ack_m0_rdata", m0_rdata, ma.r0);
          chk("ack_m1_rdata", m1_rdata, ma.r1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    sys_rst_i = 1'b0;
    m0_req = 0; m0_rd = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0; m0_lock = 0;
    m1_req = 0; m1_rd = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;
    io_din = 16'h0;
    repeat (3) @(negedge sys_clk_i);
    check_zero("reset");

    // m0 write issued in the same cycle reset is released
    @(negedge sys_clk_i); c = cyc;
    sys_rst_i = 1'b1;
    set_m0(0, 1, 16'h6700, 16'h1234, 0);
    push_s(c + 1, 1, 16'h6700, 16'h1234, 0);
    push_a(c + 4, 0, 16'h0000, 16'h0000);
    wait_acks(1, "m0_write", 0);

    // m0 read captures io_din
    @(negedge sys_clk_i); c = cyc;
    io_din = 16'h5A5A;
    set_m0(1, 0, 16'h0010, 16'h0000, 0);
    push_s(c + 1, 0, 16'h0010, 16'h0000, 0);
    push_a(c + 4, 0, 16'h5A5A, 16'h0000);
    wait_acks(1, "m0_read", 0);

    // rd and wr both set: write only, no capture
    @(negedge sys_clk_i); c = cyc;
    io_din = 16'h1111;
    set_m0(1, 1, 16'h0020, 16'hAAAA, 0);
    push_s(c + 1, 1, 16'h0020, 16'hAAAA, 0);
    push_a(c + 4, 0, 16'h5A5A, 16'h0000);
    wait_acks(1, "m0_rdwr", 0);

    // neither rd nor wr: no strobe, still acked
    @(negedge sys_clk_i); c = cyc;
    io_din = 16'h2222;
    set_m0(0, 0, 16'h0030, 16'h0000, 0);
    push_a(c + 4, 0, 16'h5A5A, 16'h0000);
    wait_acks(1, "m0_noop", 0);

    // m1 read leaves m0_rdata untouched
    @(negedge sys_clk_i); c = cyc;
    io_din = 16'hBEEF;
    set_m1(1, 0, 16'h7102, 16'h0000, 0);
    push_s(c + 1, 0, 16'h7102, 16'h0000, 1);
    push_a(c + 4, 1, 16'h5A5A, 16'hBEEF);
    wait_acks(1, "m1_read", 0);

    // both request continuously: m0, m1, m0, m1 with strobes 5 apart
    @(negedge sys_clk_i); c = cyc;
    io_din = 16'hC0DE;
    set_m0(0, 1, 16'h1000, 16'h0001, 0);
    set_m1(1, 0, 16'h2000, 16'h0000, 0);
    push_s(c + 1,  1, 16'h1000, 16'h0001, 0);
    push_s(c + 6,  0, 16'h2000, 16'h0000, 1);
    push_s(c + 11, 1, 16'h1000, 16'h0001, 0);
    push_s(c + 16, 0, 16'h2000, 16'h0000, 1);
    push_a(c + 4,  0, 16'h5A5A, 16'hBEEF);
    push_a(c + 9,  1, 16'h5A5A, 16'hC0DE);
    push_a(c + 14, 0, 16'h5A5A, 16'hC0DE);
    push_a(c + 19, 1, 16'h5A5A, 16'hC0DE);
    wait_acks(4, "alternate", 0);

    // m0 locked: three back-to-back m0 grants, then m1 by the pointer
    @(negedge sys_clk_i); c = cyc;
    io_din = 16'h7777;
    set_m0(0, 1, 16'h3000, 16'h00AA, 1);
    set_m1(1, 0, 16'h4000, 16'h0000, 0);
    push_s(c + 1,  1, 16'h3000, 16'h00AA, 0);
    push_s(c + 6,  1, 16'h3000, 16'h00AA, 0);
    push_s(c + 11, 1, 16'h3000, 16'h00AA, 0);
    push_s(c + 16, 0, 16'h4000, 16'h0000, 1);
    push_a(c + 4,  0, 16'h5A5A, 16'hC0DE);
    push_a(c + 9,  0, 16'h5A5A, 16'hC0DE);
    push_a(c + 14, 0, 16'h5A5A, 16'hC0DE);
    push_a(c + 19, 1, 16'h5A5A, 16'h7777);
    wait_acks(4, "lock", 1);

    // reset during HOLD of an m1 read aborts it
    @(negedge sys_clk_i); c = cyc;
    io_din = 16'h9999;
    set_m1(1, 0, 16'h5000, 16'h0000, 0);
    push_s(c + 1, 0, 16'h5000, 16'h0000, 1);
    repeat (2) @(negedge sys_clk_i);
    sys_rst_i = 1'b0;
    m1_req = 1'b0;
    #1;
    check_zero("midreset");
    repeat (2) @(negedge sys_clk_i);
    c = cyc;
    sys_rst_i = 1'b1;
    set_m0(0, 1, 16'h6000, 16'h0BAD, 0);
    push_s(c + 1, 1, 16'h6000, 16'h0BAD, 0);
    push_a(c + 4, 0, 16'h0000, 16'h0000);
    wait_acks(1, "post_reset", 0);

    repeat (10) @(negedge sys_clk_i);
    chk("strobe_queue_left", sq.size(), 0);
    chk("ack_queue_left", aq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, IO address width.
REQ-002 Parameter DATA_W, default 16, IO data width.
REQ-003 Parameter ACCESS_CYCLES, default 2, number of HOLD cycles per access; legal range 1..15.
REQ-004 sys_clk_i  input  1  sole clock, rising-edge.
REQ-005 sys_rst_i  input  1  asynchronous, active-low reset.
REQ-006 m0_req, m1_req  input  1 each  master request; held high until the matching ack.
REQ-007 m0_rd/m0_wr, m1_rd/m1_wr  input  1 each  access type, sampled at grant.
REQ-008 m0_addr, m1_addr  input  ADDR_W each  access address, sampled at grant.
REQ-009 m0_wdata, m1_wdata  input  DATA_W each  write data, sampled at grant.
REQ-010 m0_lock, m1_lock  input  1 each  burst lock, sampled at grant.
REQ-011 m0_ack, m1_ack  output  1 each  one-cycle completion pulse.
REQ-012 m0_rdata, m1_rdata  output  DATA_W each  captured read data.
REQ-013 io_rd, io_wr  output  1 each  one-cycle strobes to the peripheral bus (address decoder and peripherals).
REQ-014 io_addr, io_dout  output  ADDR_W, DATA_W  latched address and write data to the bus.
REQ-015 io_din  input  DATA_W  muxed read data returned from the bus.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 owner  output  1  index of the granted master (0/1), valid while busy.

Function
REQ-018 FSM states: IDLE, STROBE, HOLD, DONE; the state register is the only control state besides the hold counter, the round-robin pointer and the lock flag.
REQ-019 IDLE: no req -> stay; any req -> latch winner's rd, wr, addr, wdata and lock, set owner, go STROBE.
REQ-020 Arbitration: single requester wins; if both request, the master not granted last wins; pointer initial value favours m0.
REQ-021 Lock: if the lock flag is set and the previous owner requests in IDLE, that owner wins regardless of the pointer; the lock flag is cleared at any grant with lock=0.
REQ-022 STROBE: exactly one cycle; io_wr=1 if latched wr, else io_rd=1 if latched rd; wr takes precedence when both are set; neither set -> no strobe (no-op access, still acked).
REQ-023 io_addr and io_dout hold the latched values from STROBE through DONE and keep their last values otherwise.
REQ-024 HOLD: lasts exactly ACCESS_CYCLES cycles; on the last HOLD cycle io_din is captured into the owner's rdata register (read accesses only).
REQ-025 DONE: owner's ack=1 for exactly one cycle; the pointer is updated to the owner; next state is IDLE.
REQ-026 Latency: req sampled in IDLE at cycle N -> strobe at N+1 -> ack at N+2+ACCESS_CYCLES; with the default, ack at N+4.
REQ-027 mX_rdata holds its value until the next read capture for that master; the other master's rdata is unchanged.
REQ-028 A req deasserted before ack does not abort the access; the access completes and the ack is still pulsed.
REQ-029 A req still high in the IDLE cycle after DONE is a new access (back-to-back); the minimum spacing between consecutive strobes is 3+ACCESS_CYCLES cycles.
REQ-030 A request arriving while busy waits; it is never dropped and is served at the next IDLE under REQ-020/021.
REQ-031 Never both acks high; never both io_rd and io_wr high.

Reset
REQ-032 While sys_rst_i=0: state=IDLE; io_rd, io_wr, m0_ack, m1_ack, busy, owner=0; io_addr, io_dout, m0_rdata, m1_rdata=0; pointer favours m0; lock flag cleared; hold counter=0.
REQ-033 Reset asserted mid-access aborts the access immediately: no strobe and no ack are issued for it after release.
REQ-034 First grant is possible in the first rising edge after sys_rst_i returns high.

Structure
REQ-035 Shared package io_arb_pkg holds the FSM state encoding, the master index constants M0/M1 and the default ACCESS_CYCLES.
REQ-036 Sub-module rr_pick2 is the combinational two-way round-robin/lock winner selector; the FSM, counter and registers live in io_bus_arbiter.

Verification
REQ-037 m0 write addr 0x6700 data 0x1234 alone -> io_wr pulse at cycle 1 with io_addr=0x6700 and io_dout=0x1234; m0_ack at cycle 4; no m1_ack.
REQ-038 m1 read 0x7102 with io_din=0xBEEF -> io_rd at cycle 1; m1_rdata=0xBEEF at ack (cycle 4); m0_rdata unchanged.
REQ-039 m0 and m1 both request continuously with lock=0 -> grants alternate m0, m1, m0, m1; strobes 5 cycles apart.
REQ-040 m0 requests with lock=1, m1 requests continuously -> m0 is served back-to-back until m0 drops lock; then m1 is granted.
REQ-041 sys_rst_i low during HOLD of an m1 read -> all outputs 0 at once; no m1_ack after release; a fresh m0 request after release is acked 4 cycles later.
REQ-042 m0 request with rd=wr=1 -> only io_wr pulses; with rd=wr=0 -> no strobe, m0_ack still at cycle 4.
